traffic_light_ctrl: RTL and testbench
=====================================

Name: traffic_light_ctrl

Overview:
- Two-road (north-south / east-west) traffic light sequencer.
- Sits directly downstream of the 1 Hz generator. Consumes its clk_1Hz square wave as a level signal on the 74.25 MHz system clock and converts it into a one-cycle seconds tick.
- Runs the light phase state machine with per-phase countdown, plus a night (flashing yellow) mode.
- Drives lamp outputs and a seconds-remaining value for the display stage.

Parameters:
- GREEN_S, 25, green phase duration in seconds (>=1).
- YELLOW_S, 3, yellow phase duration in seconds (>=1).
- ALLRED_S, 2, all-red clearance duration in seconds (>=1).
- CNT_W, 7, countdown/sec_left width. Elaboration error if any duration is >= 2^CNT_W or < 1.

Ports:
- clk  input  1  system clock, 74.25 MHz.
- rst  input  1  synchronous, active-high reset.
- clk_1Hz  input  1  1 Hz square wave from the generator, same clock domain.
- night_mode  input  1  asynchronous switch; high requests flashing-yellow mode.
- ns_light  output  3  north-south lamps {red,yellow,green}, one-hot except in night mode.
- ew_light  output  3  east-west lamps, same encoding.
- sec_left  output  CNT_W  seconds remaining in the current phase.
- tick_1s  output  1  one-cycle pulse per 1 Hz rising edge (debug/display strobe).

Behaviour:
- Reset: one clock; reset is synchronous and active-high. While rst=1 at a clk edge:
  - Edge-detect registers s1 and s_prev are both loaded with the current clk_1Hz, so there is no spurious tick after release.
  - night_mode synchronizer is cleared to 0.
  - State = ALL_RED_2, counter = ALLRED_S, flash = 1.
  - Outputs: ns_light = ew_light = 3'b100, sec_left = ALLRED_S, tick_1s = 0.
- Tick generation:
  - s1 <= clk_1Hz; s_prev <= s1; tick = s1 & ~s_prev, registered into tick_1s.
  - tick_1s is high exactly 1 cycle, 2 clk cycles after clk_1Hz rises. The falling edge produces nothing.
- night_mode: 2-flop synchronizer giving night_s. It is evaluated only on tick cycles.
- States: NS_GREEN, NS_YELLOW, ALL_RED_1, EW_GREEN, EW_YELLOW, ALL_RED_2, NIGHT.
- On a tick cycle, outside NIGHT:
  - If night_s=1: go to NIGHT, flash <= 1, counter <= 0. This has priority over the countdown.
  - Else if counter == 1: advance and load the next phase duration. Order is NS_GREEN(GREEN_S) -> NS_YELLOW(YELLOW_S) -> ALL_RED_1(ALLRED_S) -> EW_GREEN(GREEN_S) -> EW_YELLOW(YELLOW_S) -> ALL_RED_2(ALLRED_S) -> NS_GREEN.
  - Else: counter decrements by 1. It never wraps; counter is never 0 outside NIGHT.
- On a tick cycle in NIGHT:
  - If night_s=0: go to ALL_RED_2, counter <= ALLRED_S. Exit from night always passes through all-red.
  - Else: flash <= ~flash.
- Non-tick cycles: state, counter and flash hold.
- Full non-night cycle = 2*(GREEN_S+YELLOW_S+ALLRED_S) ticks (60 at defaults).
- Lamp decode (outputs registered, updated the same edge as the state, i.e. 1 cycle after tick_1s asserts):
  - NS_GREEN: NS 001 / EW 100.
  - NS_YELLOW: NS 010 / EW 100.
  - ALL_RED_x: 100 / 100.
  - EW_GREEN: 100 / 001.
  - EW_YELLOW: 100 / 010.
  - NIGHT: both {0,flash,0}.
- sec_left = counter (0 in NIGHT).
- Safety invariant: outside NIGHT, at least one road shows 3'b100 on every cycle; never both green or yellow.
- rst mid-phase: the next edge forces the reset values regardless of state, tick or night_mode.

Decomposition:
- Shared package traffic_pkg:
  - state enum (7 states);
  - lamp constants LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001, LAMP_OFF=3'b000;
  - default duration constants.
- One sub-module, tick_edge_det: the s1/s_prev registers plus rising-edge pulse, with reset-loads-input behaviour. It is reusable by the display stage.

Test Plan:
- Hold clk_1Hz=1 through reset, release, wait 100 cycles -> tick_1s stays 0, both lights 3'b100, sec_left=2.
- Defaults, drive clk_1Hz edges -> 2 ticks after reset NS=001/EW=100 with sec_left=25; 25 ticks later NS=010, sec_left=3; after 60 ticks total from the first NS_GREEN it is back in NS_GREEN with sec_left=25; the safety invariant is checked every cycle.
- With GREEN_S=4, YELLOW_S=2, ALLRED_S=1, assert night_mode during NS_GREEN at sec_left=3 -> at the first tick after sync both lights 010 and sec_left=0, next tick 000, then alternating per tick.
- Deassert night_mode while in NIGHT -> next tick both 100 with sec_left=ALLRED_S, then NS_GREEN with sec_left=GREEN_S.
- Pulse rst for 1 cycle during EW_YELLOW -> next edge both 100, sec_left=ALLRED_S, tick_1s=0; no tick if clk_1Hz is high at release.
- night_mode glitch shorter than 1 tick period between ticks -> no state change.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types, lamp encodings and phase-sequencing helpers for the
// two-road traffic light controller.
package traffic_pkg;

    // Light phases; NIGHT is the flashing-yellow maintenance mode.
    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_1 = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_2 = 3'd5,
        NIGHT     = 3'd6
    } state_t;

    // Lamp vectors are {red, yellow, green}.
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    // Default phase durations in seconds.
    localparam int DEF_GREEN_S  = 25;
    localparam int DEF_YELLOW_S = 3;
    localparam int DEF_ALLRED_S = 2;
    localparam int DEF_CNT_W    = 7;

    // Successor in the normal day cycle; NIGHT always leaves via all-red.
    function automatic state_t next_phase(input state_t s);
        state_t n;
        n = ALL_RED_2;
        case (s)
            NS_GREEN:  n = NS_YELLOW;
            NS_YELLOW: n = ALL_RED_1;
            ALL_RED_1: n = EW_GREEN;
            EW_GREEN:  n = EW_YELLOW;
            EW_YELLOW: n = ALL_RED_2;
            ALL_RED_2: n = NS_GREEN;
            default:   n = ALL_RED_2;
        endcase
        return n;
    endfunction

    // North-south lamp pattern for a given phase and flash phase.
    function automatic logic [2:0] ns_lamp(input state_t s, input logic flash);
        logic [2:0] l;
        l = LAMP_RED;
        case (s)
            NS_GREEN:  l = LAMP_GRN;
            NS_YELLOW: l = LAMP_YEL;
            NIGHT:     l = flash ? LAMP_YEL : LAMP_OFF;
            default:   l = LAMP_RED;
        endcase
        return l;
    endfunction

    // East-west lamp pattern for a given phase and flash phase.
    function automatic logic [2:0] ew_lamp(input state_t s, input logic flash);
        logic [2:0] l;
        l = LAMP_RED;
        case (s)
            EW_GREEN:  l = LAMP_GRN;
            EW_YELLOW: l = LAMP_YEL;
            NIGHT:     l = flash ? LAMP_YEL : LAMP_OFF;
            default:   l = LAMP_RED;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_tick_edge_det.sv
// Rising-edge detector for a slow level signal already in the clk domain.
// Reset loads both history flops with the live input so that a level that
// is already high at reset release never produces a pulse.
module tick_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic s1;
    logic s_prev;

    // Two-deep history of the input level.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= level;
            s_prev <= level;
        end else begin
            s1     <= level;
            s_prev <= s1;
        end
    end

    assign pulse = s1 & ~s_prev;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light sequencer driven by a 1 Hz square wave.
// The seconds tick is registered into tick_1s; the phase machine acts on
// that registered tick, so lamps change one cycle after tick_1s asserts.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int GREEN_S  = DEF_GREEN_S,
    parameter int YELLOW_S = DEF_YELLOW_S,
    parameter int ALLRED_S = DEF_ALLRED_S,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_1Hz,
    input  logic             night_mode,
    output logic [2:0]       ns_light,
    output logic [2:0]       ew_light,
    output logic [CNT_W-1:0] sec_left,
    output logic             tick_1s
);

    // Every duration must be loadable into the countdown and be non-zero,
    // otherwise the "counter is never 0 outside NIGHT" property breaks.
    if (GREEN_S < 1 || GREEN_S >= (1 << CNT_W)) begin : g_bad_green
        $error("traffic_light_ctrl: GREEN_S out of range for CNT_W");
    end
    if (YELLOW_S < 1 || YELLOW_S >= (1 << CNT_W)) begin : g_bad_yellow
        $error("traffic_light_ctrl: YELLOW_S out of range for CNT_W");
    end
    if (ALLRED_S < 1 || ALLRED_S >= (1 << CNT_W)) begin : g_bad_allred
        $error("traffic_light_ctrl: ALLRED_S out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_S);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_S);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_S);

    logic             tick;
    logic             night_meta;
    logic             night_s;
    state_t           state;
    logic [CNT_W-1:0] counter;
    logic             flash;

    // Duration loaded when a phase is entered.
    function automatic logic [CNT_W-1:0] phase_len(input state_t s);
        logic [CNT_W-1:0] d;
        d = ALLRED_LD;
        case (s)
            NS_GREEN, EW_GREEN:   d = GREEN_LD;
            NS_YELLOW, EW_YELLOW: d = YELLOW_LD;
            default:              d = ALLRED_LD;
        endcase
        return d;
    endfunction

    tick_edge_det u_tick_edge_det (
        .clk   (clk),
        .rst   (rst),
        .level (clk_1Hz),
        .pulse (tick)
    );

    // Register the edge pulse so the strobe is glitch-free and one cycle wide.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_1s <= 1'b0;
        end else begin
            tick_1s <= tick;
        end
    end

    // Two-flop synchronizer for the asynchronous night switch.
    always_ff @(posedge clk) begin
        if (rst) begin
            night_meta <= 1'b0;
            night_s    <= 1'b0;
        end else begin
            night_meta <= night_mode;
            night_s    <= night_meta;
        end
    end

    // Phase machine: advances only on tick_1s, lamps registered alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ALL_RED_2;
            counter  <= ALLRED_LD;
            flash    <= 1'b1;
            ns_light <= LAMP_RED;
            ew_light <= LAMP_RED;
        end else if (tick_1s) begin
            if (state != NIGHT) begin
                if (night_s) begin
                    // Night request wins over any countdown in progress.
                    state    <= NIGHT;
                    counter  <= '0;
                    flash    <= 1'b1;
                    ns_light <= ns_lamp(NIGHT, 1'b1);
                    ew_light <= ew_lamp(NIGHT, 1'b1);
                end else if (counter == CNT_W'(1)) begin
                    state    <= next_phase(state);
                    counter  <= phase_len(next_phase(state));
                    ns_light <= ns_lamp(next_phase(state), flash);
                    ew_light <= ew_lamp(next_phase(state), flash);
                end else begin
                    counter  <= counter - CNT_W'(1);
                end
            end else begin
                if (!night_s) begin
                    // Leaving night always clears the junction first.
                    state    <= ALL_RED_2;
                    counter  <= ALLRED_LD;
                    ns_light <= LAMP_RED;
                    ew_light <= LAMP_RED;
                end else begin
                    flash    <= ~flash;
                    ns_light <= ns_lamp(NIGHT, ~flash);
                    ew_light <= ew_lamp(NIGHT, ~flash);
                end
            end
        end
    end

    // The countdown register is already zero in NIGHT.
    assign sec_left = counter;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench: one default-parameter controller for the day cycle and
// reset behaviour, one short-duration controller for night mode.
module tb_traffic_light_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       hz_a, hz_b;
    logic       night_a, night_b;
    logic [2:0] ns_a, ew_a, ns_b, ew_b;
    logic [6:0] sec_a, sec_b;
    logic       tick_a, tick_b;

    int n_assert = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;
    bit seen;

    traffic_light_ctrl dut_a (
        .clk        (clk),
        .rst        (rst),
        .clk_1Hz    (hz_a),
        .night_mode (night_a),
        .ns_light   (ns_a),
        .ew_light   (ew_a),
        .sec_left   (sec_a),
        .tick_1s    (tick_a)
    );

    traffic_light_ctrl #(
        .GREEN_S  (4),
        .YELLOW_S (2),
        .ALLRED_S (1),
        .CNT_W    (7)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .clk_1Hz    (hz_b),
        .night_mode (night_b),
        .ns_light   (ns_b),
        .ew_light   (ew_b),
        .sec_left   (sec_b),
        .tick_1s    (tick_b)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic lamps_a(input string tag, input logic [2:0] ns, input logic [2:0] ew, input int sec);
        check({tag, "_ns_a"}, 32'(ns_a), 32'(ns));
        check({tag, "_ew_a"}, 32'(ew_a), 32'(ew));
        check({tag, "_sec_a"}, 32'(sec_a), 32'(sec));
    endtask

    task automatic lamps_b(input string tag, input logic [2:0] ns, input logic [2:0] ew, input int sec);
        check({tag, "_ns_b"}, 32'(ns_b), 32'(ns));
        check({tag, "_ew_b"}, 32'(ew_b), 32'(ew));
        check({tag, "_sec_b"}, 32'(sec_b), 32'(sec));
    endtask

    // One compressed 1 Hz period: 4 cycles high, 4 low.
    task automatic pulse_a(input int n);
        for (int i = 0; i < n; i++) begin
            hz_a = 1'b1; step(4);
            hz_a = 1'b0; step(4);
        end
    endtask

    task automatic pulse_b(input int n);
        for (int i = 0; i < n; i++) begin
            hz_b = 1'b1; step(4);
            hz_b = 1'b0; step(4);
        end
    endtask

    function automatic bit safe(input logic [2:0] ns, input logic [2:0] ew);
        return (ns == 3'b100) || (ew == 3'b100) ||
               ((ns == ew) && (ns == 3'b010 || ns == 3'b000));
    endfunction

    // Safety invariant on every cycle for both controllers.
    always @(negedge clk) begin
        if (mon_en && rst === 1'b0) begin
            n_assert++;
            assert (safe(ns_a, ew_a)) else begin
                n_fail++;
                $error("FAIL safety_a observed=%b/%b expected=one road red", ns_a, ew_a);
            end
            n_assert++;
            assert (safe(ns_b, ew_b)) else begin
                n_fail++;
                $error("FAIL safety_b observed=%b/%b expected=one road red", ns_b, ew_b);
            end
        end
    end

    initial begin
        rst = 1'b1; hz_a = 1'b1; hz_b = 1'b1; night_a = 1'b0; night_b = 1'b0;
        step(3);
        lamps_a("rst", 3'b100, 3'b100, 2);
        lamps_b("rst", 3'b100, 3'b100, 1);
        check("rst_tick_a", 32'(tick_a), 0);

        // Release with the 1 Hz input already high: no tick may appear.
        rst = 1'b0;
        mon_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (tick_a || tick_b) seen = 1'b1;
        end
        check("no_tick_after_rel", 32'(seen), 0);
        lamps_a("idle", 3'b100, 3'b100, 2);
        lamps_b("idle", 3'b100, 3'b100, 1);

        hz_a = 1'b0; hz_b = 1'b0;
        step(4);

        // First tick with exact strobe timing.
        hz_a = 1'b1;
        step(1); check("tick_e0", 32'(tick_a), 0);
        step(1); check("tick_e1", 32'(tick_a), 1);
        step(1); check("tick_e2", 32'(tick_a), 0);
        lamps_a("t1", 3'b100, 3'b100, 1);
        step(1);
        hz_a = 1'b0;
        step(2); check("no_fall_tick", 32'(tick_a), 0);
        step(2);

        // Full day cycle at default durations.
        pulse_a(1);  lamps_a("ns_green", 3'b001, 3'b100, 25);
        pulse_a(24); lamps_a("ns_green_end", 3'b001, 3'b100, 1);
        pulse_a(1);  lamps_a("ns_yellow", 3'b010, 3'b100, 3);
        pulse_a(3);  lamps_a("all_red_1", 3'b100, 3'b100, 2);
        pulse_a(2);  lamps_a("ew_green", 3'b100, 3'b001, 25);
        pulse_a(25); lamps_a("ew_yellow", 3'b100, 3'b010, 3);
        pulse_a(3);  lamps_a("all_red_2", 3'b100, 3'b100, 2);
        pulse_a(2);  lamps_a("wrap_ns_green", 3'b001, 3'b100, 25);
        pulse_a(55); lamps_a("ew_yellow2", 3'b100, 3'b010, 3);
        pulse_a(1);  lamps_a("ew_yellow2_dec", 3'b100, 3'b010, 2);

        // Night mode on the short-duration controller.
        pulse_b(1); lamps_b("b_ns_green", 3'b001, 3'b100, 4);
        pulse_b(1); lamps_b("b_ns_green_dec", 3'b001, 3'b100, 3);
        night_b = 1'b1;
        pulse_b(1); lamps_b("night_on", 3'b010, 3'b010, 0);
        pulse_b(1); lamps_b("night_off_ph", 3'b000, 3'b000, 0);
        pulse_b(1); lamps_b("night_on_ph", 3'b010, 3'b010, 0);
        night_b = 1'b0;
        pulse_b(1); lamps_b("night_exit", 3'b100, 3'b100, 1);
        pulse_b(1); lamps_b("after_night", 3'b001, 3'b100, 4);
        pulse_b(1); lamps_b("after_night_dec", 3'b001, 3'b100, 3);

        // Short night glitch between ticks must be ignored.
        night_b = 1'b1; step(2);
        night_b = 1'b0; step(3);
        lamps_b("glitch_hold", 3'b001, 3'b100, 3);
        pulse_b(1); lamps_b("glitch_tick", 3'b001, 3'b100, 2);

        // Reset pulse during EW_YELLOW while the 1 Hz input rises.
        hz_a = 1'b1; rst = 1'b1;
        step(1);
        lamps_a("midrst", 3'b100, 3'b100, 2);
        lamps_b("midrst", 3'b100, 3'b100, 1);
        check("midrst_tick", 32'(tick_a), 0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (tick_a) seen = 1'b1;
        end
        check("midrst_no_tick", 32'(seen), 0);
        lamps_a("midrst_hold", 3'b100, 3'b100, 2);
        hz_a = 1'b0; step(4);
        pulse_a(1); lamps_a("post_rst_t1", 3'b100, 3'b100, 1);
        pulse_a(1); lamps_a("post_rst_t2", 3'b001, 3'b100, 25);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
